// File: rtl/sha256_msg_sequencer.sv
// SHA-256 message front end: collects 32-bit words, appends padding and the
// bit length, and issues 512-bit blocks to the compression core, chaining hashes.
//
// state     | meaning
// S_COLLECT | accepting message words into blk_buf
// S_PAD     | appending 0x80 marker, zero fill and bit length
// S_ISSUE   | one-cycle start pulse to the core
// S_WAIT    | waiting for core_done, then chain / rebuild / return
// S_DONE    | present digest, reset chaining value for the next message
`timescale 1ns/1ps
module sha256_msg_sequencer #(
  parameter int LEN_W = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              msg_valid,
  input  logic [31:0]       msg_word,
  input  logic              msg_last,
  output logic              msg_ready,
  output logic              core_start,
  output logic [15:0][31:0] core_message,
  output logic [7:0][31:0]  core_hash,
  input  logic              core_done,
  input  logic [7:0][31:0]  core_sha,
  output logic              digest_valid,
  output logic [7:0][31:0]  digest,
  output logic              busy
);

  typedef enum logic [2:0] {S_COLLECT, S_PAD, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  state_t              state, state_nxt;
  logic [15:0][31:0]   blk_buf;
  logic [4:0]          pos;
  logic [LEN_W-1:0]    nwords;
  logic [7:0][31:0]    chain;
  logic [7:0][31:0]    digest_q;
  logic                final_blk;
  logic                extra_blk;
  logic [31:0]         len_bits;

  assign len_bits     = 32'({nwords, 5'b00000});
  assign core_message = blk_buf;
  assign core_hash    = chain;
  assign busy         = !((state == S_COLLECT) && (pos == 5'd0));
  // The digest becomes visible in the same cycle as its valid pulse.
  assign digest       = (state == S_DONE) ? chain : digest_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_COLLECT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    msg_ready    = 1'b0;
    core_start   = 1'b0;
    digest_valid = 1'b0;
    case (state)
      S_COLLECT: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          if (msg_last)            state_nxt = S_PAD;
          else if (pos == 5'd15)   state_nxt = S_ISSUE;
        end
      end
      S_PAD:   state_nxt = S_ISSUE;
      S_ISSUE: begin
        core_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          if (final_blk)      state_nxt = S_DONE;
          else if (extra_blk) state_nxt = S_ISSUE;
          else                state_nxt = S_COLLECT;
        end
      end
      S_DONE: begin
        digest_valid = 1'b1;
        state_nxt    = S_COLLECT;
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_buf   <= '0;
      pos       <= '0;
      nwords    <= '0;
      chain     <= IV;
      digest_q  <= '0;
      final_blk <= 1'b0;
      extra_blk <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (msg_valid) begin
            blk_buf[pos[3:0]] <= msg_word;
            pos               <= pos + 5'd1;
            nwords            <= nwords + LEN_W'(1);
            if (!msg_last && (pos == 5'd15)) final_blk <= 1'b0;
          end
        end
        S_PAD: begin
          for (int i = 0; i < 16; i++) begin
            if (5'(i) > pos) blk_buf[i] <= 32'h0;
          end
          if (pos <= 5'd15) blk_buf[pos[3:0]] <= 32'h80000000;
          if (pos <= 5'd13) begin
            blk_buf[14] <= 32'h0;
            blk_buf[15] <= len_bits;
            final_blk   <= 1'b1;
          end else begin
            // No room for the length field: it goes into a trailing block.
            extra_blk <= 1'b1;
            final_blk <= 1'b0;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            chain <= core_sha;
            if (!final_blk) begin
              if (extra_blk) begin
                blk_buf     <= '0;
                blk_buf[0]  <= (pos == 5'd16) ? 32'h80000000 : 32'h0;
                blk_buf[15] <= len_bits;
                final_blk   <= 1'b1;
                extra_blk   <= 1'b0;
              end else begin
                pos <= '0;
              end
            end
          end
        end
        S_DONE: begin
          digest_q  <= chain;
          chain     <= IV;
          pos       <= '0;
          nwords    <= '0;
          final_blk <= 1'b0;
          extra_blk <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Bench for sha256_msg_sequencer: behavioural SHA-256 core plus a padding /
// chaining reference model, with one negedge compare process.
`timescale 1ns/1ps
module tb_sha256_msg_sequencer;

  typedef logic [15:0][31:0] blk_t;
  typedef logic [7:0][31:0]  hash_t;

  localparam hash_t IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        msg_valid = 1'b0;
  logic [31:0] msg_word = 32'h0;
  logic        msg_last = 1'b0;
  logic        msg_ready;
  logic        core_start;
  blk_t        core_message;
  hash_t       core_hash;
  logic        core_done = 1'b0;
  hash_t       core_sha = '0;
  logic        digest_valid;
  hash_t       digest;
  logic        busy;

  sha256_msg_sequencer #(.LEN_W(27)) dut (
    .clk(clk), .reset(reset),
    .msg_valid(msg_valid), .msg_word(msg_word), .msg_last(msg_last), .msg_ready(msg_ready),
    .core_start(core_start), .core_message(core_message), .core_hash(core_hash),
    .core_done(core_done), .core_sha(core_sha),
    .digest_valid(digest_valid), .digest(digest), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic hash_t compress(input hash_t h, input blk_t b);
    logic [31:0] w [64];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2, s0, s1;
    hash_t r;
    for (int i = 0; i < 16; i++) w[i] = b[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = h[0]; bb = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    r[0] = h[0] + a;  r[1] = h[1] + bb; r[2] = h[2] + c;  r[3] = h[3] + d;
    r[4] = h[4] + e;  r[5] = h[5] + f;  r[6] = h[6] + g;  r[7] = h[7] + hh;
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [31:0] cur_msg [$];
  blk_t  exp_blk [$];
  hash_t exp_hash [$];
  hash_t exp_dig [$];
  int    exp_due [$];
  blk_t  seen_blk [$];
  hash_t seen_dig = '0;
  hash_t last_dig = '0;
  hash_t last_model_dig;
  bit    model_extra;
  int    starts = 0;
  int    prev_t = 0;
  int    prev_due = 0;

  // Behavioural core: sample start, 65 compute cycles, one cycle of done.
  logic  core_act = 1'b0;
  int    core_cnt = 0;
  blk_t  cap_blk;
  hash_t cap_hash;
  always @(posedge clk) begin
    if (reset) begin
      core_act  <= 1'b0;
      core_done <= 1'b0;
    end else begin
      core_done <= 1'b0;
      if (core_act) begin
        if (core_cnt == 1) begin
          core_done <= 1'b1;
          core_sha  <= compress(cap_hash, cap_blk);
          core_act  <= 1'b0;
        end
        core_cnt <= core_cnt - 1;
      end else if (core_start) begin
        core_act <= 1'b1;
        core_cnt <= 65;
        cap_blk  <= core_message;
        cap_hash <= core_hash;
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (reset) begin
      exp_blk.delete(); exp_hash.delete(); exp_dig.delete(); exp_due.delete();
      last_dig = '0;
    end else begin
      if (core_start) begin
        starts++;
        seen_blk.push_back(core_message);
        chk("start_while_core_busy", 512'(core_act), 512'(1'b0));
        if (exp_blk.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_core_start actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          chk("block", 512'(core_message), 512'(exp_blk.pop_front()));
          chk("chain", 512'(core_hash), 512'(exp_hash.pop_front()));
        end
      end
      if (core_act) begin
        chk("msg_stable", 512'(core_message), 512'(cap_blk));
        chk("hash_stable", 512'(core_hash), 512'(cap_hash));
        chk("ready_in_wait", 512'(msg_ready), 512'(1'b0));
        chk("busy_in_wait", 512'(busy), 512'(1'b1));
      end
      if (digest_valid) begin
        if (exp_dig.size() == 0 || exp_due.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_digest actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          chk("digest", 512'(digest), 512'(exp_dig.pop_front()));
          chk("digest_latency", 512'(cyc), 512'(exp_due.pop_front()));
        end
        last_dig = digest;
        seen_dig = digest;
      end else begin
        chk("digest_hold", 512'(digest), 512'(last_dig));
      end
    end
  end

  task automatic fill(input int n);
    cur_msg.delete();
    for (int i = 0; i < n; i++) cur_msg.push_back($urandom);
  endtask

  // Standard word-granular SHA-256 padding, then chained compression.
  task automatic model_msg(input int n);
    logic [31:0] p [$];
    hash_t h;
    blk_t  b;
    int    nb;
    p = cur_msg;
    p.push_back(32'h80000000);
    while (p.size() % 16 != 14) p.push_back(32'h0);
    p.push_back(32'h0);
    p.push_back(32'(n * 32));
    nb = p.size() / 16;
    h = IV;
    for (int bi = 0; bi < nb; bi++) begin
      for (int j = 0; j < 16; j++) b[j] = p[bi*16 + j];
      exp_blk.push_back(b);
      exp_hash.push_back(h);
      h = compress(h, b);
    end
    exp_dig.push_back(h);
    last_model_dig = h;
    model_extra = (((n - 1) / 16) + 1) != nb;
  endtask

  task automatic send_msg(input int n, input bit idle_ok, input bit b2b);
    int t, w;
    bit gap, ok;
    t = 0;
    model_msg(n);
    for (int i = 0; i < n; i++) begin
      gap = 1'b0;
      if (idle_ok && $urandom_range(0, 3) == 0) begin
        msg_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        gap = 1'b1;
      end
      msg_valid = 1'b1;
      msg_word  = cur_msg[i];
      msg_last  = (i == n - 1);
      w = 0; ok = 1'b0;
      while (!ok && w < 500) begin
        @(negedge clk);
        if (msg_ready) begin ok = 1'b1; t = cyc; end
        else w++;
      end
      if (!ok) begin
        errors++;
        $display("FAIL accept_timeout actual=no_accept required=accept word %0d", i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "accept timeout");
      end
      @(posedge clk); #1;
      if (i > 0 && i % 16 == 0 && !gap) chk("ready_gap", 512'(t - prev_t), 512'(68));
      if (i == 0 && b2b) chk("b2b_accept", 512'(t), 512'(prev_due + 1));
      prev_t = t;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    prev_due = t + 69 + (model_extra ? 67 : 0);
    exp_due.push_back(prev_due);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (exp_dig.size() > 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (exp_dig.size() > 0) begin
      checks++; errors++;
      $display("FAIL digest_timeout actual=pending required=none (cycle %0d)", cyc);
      exp_dig.delete(); exp_due.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_checks();
    chk("rst_ready", 512'(msg_ready), 512'(1'b1));
    chk("rst_start", 512'(core_start), 512'(1'b0));
    chk("rst_dvalid", 512'(digest_valid), 512'(1'b0));
    chk("rst_busy", 512'(busy), 512'(1'b0));
    chk("rst_digest", 512'(digest), 512'(0));
    chk("rst_chain", 512'(core_hash), 512'(IV));
    chk("rst_buf", 512'(core_message), 512'(0));
  endtask

  hash_t abcd_dig;
  blk_t  lit_blk;
  int    s0;

  initial begin
    abcd_dig = {32'h6f031589, 32'ha3e16193, 32'h23b9217d, 32'h209c8978,
                32'hf289579d, 32'h13b845fc, 32'hd4e6338d, 32'h88d4266f};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;

    // Single word "abcd"
    cur_msg = {32'h61626364};
    seen_blk.delete();
    send_msg(1, 1'b0, 1'b0);
    chk("model_abcd", 512'(last_model_dig), 512'(abcd_dig));
    wait_idle();
    lit_blk = '0; lit_blk[0] = 32'h61626364; lit_blk[1] = 32'h80000000; lit_blk[15] = 32'h20;
    if (seen_blk.size() >= 1) chk("abcd_block", 512'(seen_blk[0]), 512'(lit_blk));
    chk("abcd_digest", 512'(seen_dig), 512'(abcd_dig));

    // 20-word header
    fill(20); seen_blk.delete(); s0 = starts;
    send_msg(20, 1'b0, 1'b0);
    wait_idle();
    chk("hdr_starts", 512'(starts - s0), 512'(2));
    lit_blk = '0;
    for (int j = 0; j < 4; j++) lit_blk[j] = cur_msg[16 + j];
    lit_blk[4] = 32'h80000000; lit_blk[15] = 32'h280;
    if (seen_blk.size() >= 2) chk("hdr_block2", 512'(seen_blk[1]), 512'(lit_blk));

    // 14-word message: marker fills word 14, length needs an extra block
    fill(14); seen_blk.delete();
    send_msg(14, 1'b0, 1'b0);
    wait_idle();
    if (seen_blk.size() >= 2) begin
      chk("m14_w14", 512'(seen_blk[0][14]), 512'(32'h80000000));
      chk("m14_w15", 512'(seen_blk[0][15]), 512'(32'h0));
      lit_blk = '0; lit_blk[15] = 32'h1c0;
      chk("m14_extra", 512'(seen_blk[1]), 512'(lit_blk));
    end else chk("m14_starts", 512'(seen_blk.size()), 512'(2));

    // 16-word message, then a 3-word message offered back to back
    fill(16); seen_blk.delete();
    send_msg(16, 1'b0, 1'b0);
    fill(3);
    send_msg(3, 1'b0, 1'b1);
    wait_idle();
    lit_blk = '0; lit_blk[0] = 32'h80000000; lit_blk[15] = 32'h200;
    if (seen_blk.size() >= 2) chk("m16_extra", 512'(seen_blk[1]), 512'(lit_blk));
    else chk("m16_starts", 512'(seen_blk.size()), 512'(3));

    // Reset while block 2 of a 20-word message is in the core
    fill(20); s0 = starts;
    send_msg(20, 1'b0, 1'b0);
    begin
      int w;
      w = 0;
      while (starts < s0 + 2 && w < 300) begin @(negedge clk); w++; end
      chk("rst_wait_reached", 512'(starts - s0), 512'(2));
    end
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    cur_msg = {32'h61626364};
    send_msg(1, 1'b0, 1'b0);
    wait_idle();
    chk("abcd_after_reset", 512'(seen_dig), 512'(abcd_dig));

    // Randomized messages
    begin
      bit chained, idl;
      int n;
      chained = 1'b0;
      for (int r = 0; r < 10; r++) begin
        n = $urandom_range(1, 40);
        idl = 1'($urandom_range(0, 1));
        fill(n);
        send_msg(n, idl, chained && !idl);
        if ($urandom_range(0, 2) == 0) begin
          wait_idle();
          chained = 1'b0;
        end else chained = 1'b1;
      end
      wait_idle();
    end

    chk("blocks_drained", 512'(exp_blk.size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha256_msg_sequencer.md
# sha256_msg_sequencer

Upstream feeder for `simplified_sha256`. It accepts a message as a stream of 32-bit words and applies SHA-256 padding and the 64-bit length field. It then issues one 512-bit block at a time to the core and chains each intermediate hash into the next block. When the last block completes, it presents the final 256-bit digest, for example the first hash of an 80-byte bitcoin header.

## Interface
Parameters:
- `LEN_W`, default 27: width of the message word counter. Bit length is `words*32`, so it fits in `LEN_W+5` bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `msg_valid` in 1: a message word is offered.
- `msg_word` in 32: big-endian message word.
- `msg_last` in 1: qualifies the final word of the message. A message is at least 1 word.
- `msg_ready` out 1: the word is accepted when `msg_valid & msg_ready`.
- `core_start` out 1: one-cycle start pulse to the core.
- `core_message` out 32x16: block words. Stable from `core_start` until `core_done`.
- `core_hash` out 32x8: chaining value. Stable from `core_start` until `core_done`.
- `core_done` in 1: core completion pulse.
- `core_sha` in 32x8: core result, valid while `core_done`.
- `digest_valid` out 1: one-cycle pulse when the digest is ready.
- `digest` out 32x8: final hash. Held until the next `digest_valid`.
- `busy` out 1: high in every state except COLLECT with `pos==0`.

## Operation
- Registers:
  - `buf[16]`, `pos` (0..16), `nwords` (`LEN_W` bits).
  - `chain[8]`.
  - `final_blk` and `extra_blk` flags.
- `core_message` is driven by `buf`. `core_hash` is driven by `chain`.
- `chain` resets to the SHA-256 IV: 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
- State machine: COLLECT, PAD, ISSUE, WAIT, DONE.
- COLLECT (`msg_ready=1`): on an accepted word, `buf[pos]<=msg_word`, `pos++`, `nwords++`.
  - If `msg_last`, go to PAD.
  - Else if the new `pos==16`, set `final_blk=0` and go to ISSUE.
  - Otherwise stay in COLLECT.
- PAD (one cycle):
  - If `pos<=15`, `buf[pos]<=32'h80000000`.
  - All words above `pos` are cleared.
  - If `pos<=13`: `buf[14]<=0`, `buf[15]<=nwords*32` (low 32 bits), `final_blk<=1`.
  - Otherwise (`pos` is 14, 15 or 16): `extra_blk<=1`, `final_blk<=0`.
  - Then go to ISSUE.
- ISSUE: `core_start=1` for exactly one cycle, then go to WAIT.
- WAIT: hold until `core_done`, then `chain<=core_sha`.
  - If `final_blk`: go to DONE.
  - Else if `extra_blk`: rebuild `buf` in the same cycle as all zeros. `buf[0]=80000000` only if `pos==16`. `buf[14]=0`, `buf[15]=nwords*32`. Then set `final_blk<=1`, `extra_blk<=0`, go to ISSUE.
  - Else: `pos<=0`, go to COLLECT.
- DONE:
  - `digest<=chain` and `digest_valid=1` for one cycle.
  - `chain<=IV`; `pos`, `nwords`, flags cleared.
  - Go to COLLECT.
- The high length word (`buf[14]`) is always 0. Arithmetic is modulo 2^32.
- `msg_valid` while `msg_ready=0` is ignored and not consumed.
- `core_done` outside WAIT is ignored.

## Timing
- Reset values:
  - state COLLECT, `msg_ready=1`, `core_start=0`, `digest_valid=0`, `busy=0`.
  - `digest` all 0, `buf` all 0, `chain=IV`, counters 0.
- Reset in any state aborts the message. Any in-flight core result is discarded. The core is reset in parallel by the top level.
- Core contract:
  - The core samples `core_start` in its IDLE state. It then needs 65 COMPUTE cycles followed by 1 cycle of `core_done`.
  - ISSUE to `core_done` is 66 cycles.
  - ISSUE always follows a `core_done` by at least one cycle, so the core is idle.
- Throughput: one word per cycle in COLLECT. After word 16 of a non-final block is accepted at cycle t, `msg_ready` returns at t+68.
- Latency from acceptance of the last word to `digest_valid`:
  - 69 cycles for a single final block: PAD, ISSUE, 66 core cycles, DONE.
  - An extra padding block adds 67 cycles.
- `msg_ready=0` in PAD, ISSUE, WAIT and DONE.

## Test plan
- One word 61626364 with `msg_last`:
  - Core sees `buf` = {61626364, 80000000, 0 x 13, 00000020}.
  - `digest` = 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589, with `digest_valid` 69 cycles after the word is accepted.
- 20-word bitcoin header:
  - Expect two core starts.
  - Block 2 is {w16..w19, 80000000, 0 x 9, 0, 00000280}.
  - Digest must match the software SHA-256 model.
- 14-word message:
  - Block 1 has `buf[14]=80000000`, `buf[15]=0`.
  - The extra block is all zero except `buf[15]=000001c0`.
  - Digest must match the model.
- 16-word message:
  - The extra block has `buf[0]=80000000` and `buf[15]=00000200`.
  - Verify `msg_ready` is low and `msg_valid` is ignored throughout WAIT.
- Reset asserted during WAIT of block 2:
  - Next cycle shows reset values and `chain=IV`.
  - A following 1-word message gives the same digest as the first scenario.
- Back-to-back messages:
  - A second message offered the cycle after DONE is accepted immediately.
  - The first digest holds until the second `digest_valid`.
